// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl -- PS/2 keyboard scan-code (set 2) decoder.
//
// Pops bytes from a keyboard receiver FIFO, folds E0 (extended) and F0
// (break) prefixes into a single key event, and presents the event on a
// valid/ready interface. Tracks shift, ctrl and caps-lock state.
//
// Optional feature: define PS2_KBD_ASCII_EN to build the set-2 to ASCII
// translation table; without it evt_ascii is always 8'h00.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   kbd_data[7:0]   scan-code byte at the receiver FIFO head
//   kbd_ready       receiver FIFO non-empty
//   kbd_nextdata_n  active-low pop strobe to the receiver (one cycle)
//   evt_valid       key event available
//   evt_ready       consumer accepts the event
//   evt_code[7:0]   final scan-code byte of the event
//   evt_ext         event carried an E0 prefix
//   evt_break       event is a release (F0 prefix)
//   evt_ascii[7:0]  translated character, 8'h00 if none
//   mod_shift, mod_ctrl, mod_caps   live modifier state
//
// Parameter:
//   PREFIX_TIMEOUT  clk cycles a pending E0/F0 prefix survives while idle
module ps2_kbd_ctrl #(
    parameter logic [19:0] PREFIX_TIMEOUT = 20'd500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    output logic       kbd_nextdata_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] evt_ascii,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_caps
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DECODE,
        EMIT
    } state_t;

    state_t      state;
    logic [7:0]  byte_r;
    logic        ext_p;
    logic        brk_p;
    logic [19:0] to_cnt;
    logic        lshift_h;
    logic        rshift_h;
    logic        lctrl_h;
    logic        rctrl_h;
    logic        caps_h;
    logic        caps_r;
    logic [7:0]  ascii_next;

    // Keyboard status/ack bytes that never form a key event.
    function automatic logic is_filtered(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

`ifdef PS2_KBD_ASCII_EN
    function automatic logic [7:0] ascii_of(input logic [7:0] code,
                                            input logic       ext,
                                            input logic       brk,
                                            input logic       shift,
                                            input logic       caps);
        logic [7:0] letter;
        logic [7:0] ch;
        letter = 8'h00;
        ch     = 8'h00;
        case (code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            default: letter = 8'h00;
        endcase
        if (letter != 8'h00) begin
            // Upper case when exactly one of shift / caps-lock is active.
            ch = (shift ^ caps) ? (letter - 8'h20) : letter;
        end else begin
            case (code)
                8'h16: ch = shift ? "!" : "1";
                8'h1E: ch = shift ? "@" : "2";
                8'h26: ch = shift ? "#" : "3";
                8'h25: ch = shift ? "$" : "4";
                8'h2E: ch = shift ? "%" : "5";
                8'h36: ch = shift ? "^" : "6";
                8'h3D: ch = shift ? "&" : "7";
                8'h3E: ch = shift ? "*" : "8";
                8'h46: ch = shift ? "(" : "9";
                8'h45: ch = shift ? ")" : "0";
                8'h29: ch = 8'h20;
                8'h5A: ch = 8'h0D;
                8'h66: ch = 8'h08;
                default: ch = 8'h00;
            endcase
        end
        return (ext || brk) ? 8'h00 : ch;
    endfunction

    // Sampled in DECODE: modifiers still reflect the state before this
    // event's own handshake update.
    assign ascii_next = ascii_of(byte_r, ext_p, brk_p, mod_shift, mod_caps);
`else
    assign ascii_next = 8'h00;
`endif

    assign mod_shift = lshift_h | rshift_h;
    assign mod_ctrl  = lctrl_h | rctrl_h;
    assign mod_caps  = caps_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            byte_r         <= '0;
            ext_p          <= 1'b0;
            brk_p          <= 1'b0;
            to_cnt         <= '0;
            kbd_nextdata_n <= 1'b1;
            evt_valid      <= 1'b0;
            evt_code       <= '0;
            evt_ext        <= 1'b0;
            evt_break      <= 1'b0;
            evt_ascii      <= '0;
            lshift_h       <= 1'b0;
            rshift_h       <= 1'b0;
            lctrl_h        <= 1'b0;
            rctrl_h        <= 1'b0;
            caps_h         <= 1'b0;
            caps_r         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (kbd_ready) begin
                        byte_r         <= kbd_data;
                        to_cnt         <= '0;
                        kbd_nextdata_n <= 1'b0;
                        state          <= POP;
                    end else if (ext_p || brk_p) begin
                        // Stale prefix: drop it if no follow-up byte arrives.
                        if (to_cnt == PREFIX_TIMEOUT - 20'd1) begin
                            ext_p  <= 1'b0;
                            brk_p  <= 1'b0;
                            to_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + 20'd1;
                        end
                    end
                end

                POP: begin
                    kbd_nextdata_n <= 1'b1;
                    state          <= DECODE;
                end

                DECODE: begin
                    if (byte_r == 8'hE0) begin
                        ext_p <= 1'b1;
                        state <= IDLE;
                    end else if (byte_r == 8'hF0) begin
                        brk_p <= 1'b1;
                        state <= IDLE;
                    end else if (is_filtered(byte_r)) begin
                        ext_p <= 1'b0;
                        brk_p <= 1'b0;
                        state <= IDLE;
                    end else begin
                        evt_code  <= byte_r;
                        evt_ext   <= ext_p;
                        evt_break <= brk_p;
                        evt_ascii <= ascii_next;
                        evt_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end

                EMIT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        ext_p     <= 1'b0;
                        brk_p     <= 1'b0;
                        state     <= IDLE;
                        if (!evt_ext) begin
                            case (evt_code)
                                8'h12: lshift_h <= !evt_break;
                                8'h59: rshift_h <= !evt_break;
                                8'h14: lctrl_h  <= !evt_break;
                                8'h58: begin
                                    // Typematic repeats keep caps_h set and
                                    // therefore do not toggle again.
                                    if (!evt_break && !caps_h) caps_r <= !caps_r;
                                    caps_h <= !evt_break;
                                end
                                default: ;
                            endcase
                        end else if (evt_code == 8'h14) begin
                            rctrl_h <= !evt_break;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
module tb_ps2_kbd_ctrl;

`ifdef PS2_KBD_ASCII_EN
    localparam bit ASC_EN = 1'b1;
`else
    localparam bit ASC_EN = 1'b0;
`endif
    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_ready = 1'b0;
    logic       kbd_nextdata_n;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [7:0] evt_ascii;
    logic       mod_shift;
    logic       mod_ctrl;
    logic       mod_caps;

    ps2_kbd_ctrl #(.PREFIX_TIMEOUT(20'd16)) dut (
        .clk            (clk),
        .rst            (rst),
        .kbd_data       (kbd_data),
        .kbd_ready      (kbd_ready),
        .kbd_nextdata_n (kbd_nextdata_n),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_code       (evt_code),
        .evt_ext        (evt_ext),
        .evt_break      (evt_break),
        .evt_ascii      (evt_ascii),
        .mod_shift      (mod_shift),
        .mod_ctrl       (mod_ctrl),
        .mod_caps       (mod_caps)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned pops = 0;
    int unsigned pushes = 0;
    int unsigned dbl_pulse = 0;
    int unsigned pop_in_emit = 0;
    bit          prev_low = 1'b0;
    logic [7:0]  fifo[$];

    typedef struct {
        int unsigned n;
        logic [7:0]  b0, b1, b2;
        logic [7:0]  code;
        logic        ext, brk;
        logic [7:0]  asc;
        logic        sh, ct, cp;
    } vec_t;

    localparam int unsigned NV = 34;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance to the falling edge, model the receiver FIFO pop
    // and refresh its head/ready signals.
    task automatic step();
        @(negedge clk);
        if (!kbd_nextdata_n) begin
            pops++;
            if (prev_low) dbl_pulse++;
            if (evt_valid) pop_in_emit++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        prev_low  = !kbd_nextdata_n;
        kbd_ready = (fifo.size() > 0);
        kbd_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        pushes++;
        kbd_ready = 1'b1;
        kbd_data  = fifo[0];
    endtask

    task automatic wait_evt(output int unsigned lat);
        lat = 0;
        while (!evt_valid && lat < 40) begin
            step();
            lat++;
        end
        check("evt_arrive", evt_valid, 1'b1);
    endtask

    task automatic expect_evt(input string name, input logic [7:0] code, input logic ext,
                              input logic brk, input logic [7:0] asc);
        logic [7:0] ea;
        ea = ASC_EN ? asc : 8'h00;
        check(name, {evt_code, evt_ext, evt_break, evt_ascii}, {code, ext, brk, ea});
    endtask

    task automatic handshake();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("hs_clear", evt_valid, 1'b0);
    endtask

    initial begin : main
        int unsigned lat;
        int unsigned hold_err;
        vecs[0]  = '{1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h61, 0, 0, 0};
        vecs[1]  = '{2, 8'hF0, 8'h1C, 8'h00, 8'h1C, 0, 1, 8'h00, 0, 0, 0};
        vecs[2]  = '{1, 8'h12, 8'h00, 8'h00, 8'h12, 0, 0, 8'h00, 1, 0, 0};
        vecs[3]  = '{1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h41, 1, 0, 0};
        vecs[4]  = '{2, 8'hF0, 8'h12, 8'h00, 8'h12, 0, 1, 8'h00, 0, 0, 0};
        vecs[5]  = '{1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h61, 0, 0, 0};
        vecs[6]  = '{1, 8'h58, 8'h00, 8'h00, 8'h58, 0, 0, 8'h00, 0, 0, 1};
        vecs[7]  = '{1, 8'h58, 8'h00, 8'h00, 8'h58, 0, 0, 8'h00, 0, 0, 1};
        vecs[8]  = '{2, 8'hF0, 8'h58, 8'h00, 8'h58, 0, 1, 8'h00, 0, 0, 1};
        vecs[9]  = '{1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h41, 0, 0, 1};
        vecs[10] = '{1, 8'h16, 8'h00, 8'h00, 8'h16, 0, 0, 8'h31, 0, 0, 1};
        vecs[11] = '{1, 8'h59, 8'h00, 8'h00, 8'h59, 0, 0, 8'h00, 1, 0, 1};
        vecs[12] = '{1, 8'h16, 8'h00, 8'h00, 8'h16, 0, 0, 8'h21, 1, 0, 1};
        vecs[13] = '{1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h61, 1, 0, 1};
        vecs[14] = '{2, 8'hF0, 8'h59, 8'h00, 8'h59, 0, 1, 8'h00, 0, 0, 1};
        vecs[15] = '{2, 8'hE0, 8'h14, 8'h00, 8'h14, 1, 0, 8'h00, 0, 1, 1};
        vecs[16] = '{1, 8'h14, 8'h00, 8'h00, 8'h14, 0, 0, 8'h00, 0, 1, 1};
        vecs[17] = '{3, 8'hE0, 8'hF0, 8'h14, 8'h14, 1, 1, 8'h00, 0, 1, 1};
        vecs[18] = '{2, 8'hF0, 8'h14, 8'h00, 8'h14, 0, 1, 8'h00, 0, 0, 1};
        vecs[19] = '{3, 8'hF0, 8'hE0, 8'h75, 8'h75, 1, 1, 8'h00, 0, 0, 1};
        vecs[20] = '{3, 8'hF0, 8'hAA, 8'h1C, 8'h1C, 0, 0, 8'h41, 0, 0, 1};
        vecs[21] = '{1, 8'h29, 8'h00, 8'h00, 8'h29, 0, 0, 8'h20, 0, 0, 1};
        vecs[22] = '{1, 8'h5A, 8'h00, 8'h00, 8'h5A, 0, 0, 8'h0D, 0, 0, 1};
        vecs[23] = '{1, 8'h66, 8'h00, 8'h00, 8'h66, 0, 0, 8'h08, 0, 0, 1};
        vecs[24] = '{2, 8'hE0, 8'h1C, 8'h00, 8'h1C, 1, 0, 8'h00, 0, 0, 1};
        vecs[25] = '{1, 8'h58, 8'h00, 8'h00, 8'h58, 0, 0, 8'h00, 0, 0, 0};
        vecs[26] = '{2, 8'hF0, 8'h58, 8'h00, 8'h58, 0, 1, 8'h00, 0, 0, 0};
        vecs[27] = '{1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h61, 0, 0, 0};
        vecs[28] = '{1, 8'h45, 8'h00, 8'h00, 8'h45, 0, 0, 8'h30, 0, 0, 0};
        vecs[29] = '{1, 8'h12, 8'h00, 8'h00, 8'h12, 0, 0, 8'h00, 1, 0, 0};
        vecs[30] = '{1, 8'h59, 8'h00, 8'h00, 8'h59, 0, 0, 8'h00, 1, 0, 0};
        vecs[31] = '{2, 8'hF0, 8'h12, 8'h00, 8'h12, 0, 1, 8'h00, 1, 0, 0};
        vecs[32] = '{1, 8'h1A, 8'h00, 8'h00, 8'h1A, 0, 0, 8'h5A, 1, 0, 0};
        vecs[33] = '{2, 8'hF0, 8'h59, 8'h00, 8'h59, 0, 1, 8'h00, 0, 0, 0};

        // Reset state
        step();
        step();
        check("reset_state",
              {kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_ascii,
               mod_shift, mod_ctrl, mod_caps},
              {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        step();

        // Table-driven event sequence
        for (int unsigned i = 0; i < NV; i++) begin
            push(vecs[i].b0);
            if (vecs[i].n > 1) push(vecs[i].b1);
            if (vecs[i].n > 2) push(vecs[i].b2);
            wait_evt(lat);
            if (i == 0) check("latency_min3", (lat >= 3), 1'b1);
            expect_evt($sformatf("evt[%0d]", i), vecs[i].code, vecs[i].ext, vecs[i].brk, vecs[i].asc);
            hold_err = 0;
            for (int unsigned h = 0; h < i % 3; h++) begin
                step();
                if (!evt_valid || !kbd_nextdata_n) hold_err++;
            end
            if (i % 3 != 0) check($sformatf("hold[%0d]", i), hold_err, 0);
            handshake();
            check($sformatf("mods[%0d]", i), {mod_shift, mod_ctrl, mod_caps},
                  {vecs[i].sh, vecs[i].ct, vecs[i].cp});
            if (i == 1) check("pops_after_2evt", pops, 3);
        end

        // Reset while an event is pending in EMIT
        push(8'h12); wait_evt(lat); handshake();
        push(8'h58); wait_evt(lat); handshake();
        check("pre_rst_mods", {mod_shift, mod_caps}, 2'b11);
        push(8'h1C); wait_evt(lat);
        rst = 1'b1;
        #1;
        check("rst_emit_abort", {evt_valid, kbd_nextdata_n, mod_shift, mod_ctrl, mod_caps},
              5'b01000);
        step();
        rst = 1'b0;
        hold_err = 0;
        for (int unsigned h = 0; h < 4; h++) begin
            step();
            if (!kbd_nextdata_n || evt_valid) hold_err++;
        end
        check("post_rst_quiet", hold_err, 0);

        // Reset discards a pending prefix
        push(8'hE0);
        for (int unsigned h = 0; h < 5; h++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        push(8'h1C); wait_evt(lat);
        expect_evt("rst_no_prefix", 8'h1C, 1'b0, 1'b0, 8'h61);
        handshake();

        // Backpressure: event held with a byte waiting in the FIFO
        push(8'hE0); push(8'hF0); push(8'h75); push(8'h1C);
        wait_evt(lat);
        expect_evt("bp_evt", 8'h75, 1'b1, 1'b1, 8'h00);
        hold_err = 0;
        for (int unsigned h = 0; h < 20; h++) begin
            step();
            if (!kbd_nextdata_n || !evt_valid || fifo.size() != 1 ||
                evt_code != 8'h75 || !evt_ext || !evt_break) hold_err++;
        end
        check("backpressure", hold_err, 0);
        handshake();
        wait_evt(lat);
        expect_evt("bp_next", 8'h1C, 1'b0, 1'b0, 8'h61);
        handshake();

        // Prefix survives a short idle gap
        push(8'hE0);
        for (int unsigned h = 0; h < 8; h++) step();
        push(8'h1C); wait_evt(lat);
        expect_evt("prefix_kept", 8'h1C, 1'b1, 1'b0, 8'h00);
        handshake();

        // Prefix dropped after the timeout
        push(8'hE0);
        for (int unsigned h = 0; h < TMO + 10; h++) step();
        push(8'h1C); wait_evt(lat);
        expect_evt("prefix_timeout", 8'h1C, 1'b0, 1'b0, 8'h61);
        handshake();

        step();
        check("all_popped", pops, pushes);
        check("single_cycle_pulses", dbl_pulse, 0);
        check("no_pop_in_emit", pop_in_emit, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
